// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter.
//   NUM_SRC_MAX  : largest supported requester count
//   CNT_W        : width of the statistics counters
//   sat_add_min  : token bucket update, min(cap, max(level - sub, 0) + add), computed without wrap
package mem_arb_pkg;

   localparam int unsigned NUM_SRC_MAX = 16;
   localparam int unsigned CNT_W       = 32;

   // Operands are zero-extended to 32 bits by the caller. The sum is formed in 33 bits so a
   // level near the top of its range plus the refill cannot wrap before the ceiling is applied.
   function automatic logic [31:0] sat_add_min(input logic [31:0] level,
                                                input logic [31:0] sub,
                                                input logic [31:0] add,
                                                input logic [31:0] cap);
      logic [32:0] rem;
      logic [32:0] sum;
      rem = (sub > level) ? 33'd0 : ({1'b0, level} - {1'b0, sub});
      sum = rem + {1'b0, add};
      return (sum > {1'b0, cap}) ? cap : sum[31:0];
   endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Round-robin picker: scans req_i starting at ptr_i (wrapping) and returns the first set bit.
//   req_i  : request vector
//   ptr_i  : index with highest priority this cycle, must be < N
//   gnt_o  : one-hot grant, zero when no request
//   idx_o  : index of the granted bit
//   any_o  : at least one request present
module rr_pick_onehot #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      logic [IDX_W-1:0] j_idx;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j_idx = IDX_W'((32'(ptr_i) + k) % N);
         if (!any_o && req_i[j_idx]) begin
            any_o        = 1'b1;
            gnt_o[j_idx] = 1'b1;
            idx_o        = j_idx;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter_rr.sv
// N-source round-robin arbiter feeding a single registered memory request port.
// DRAM requests are admitted through a byte token bucket; sources waiting at least
// cfg_starve_limit cycles are promoted ahead of the round-robin order.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   src_valid/is_dram/size/ready    per-source request handshake (size flattened, SIZE_W each)
//   out_valid/is_dram/size/src_id   registered merged request, out_ready from the consumer
//   cfg_enable_tokens               0 disables DRAM gating and holds the bucket full
//   cfg_tokens_per_cycle            bucket refill per cycle
//   cfg_token_capacity              bucket ceiling
//   cfg_starve_limit                wait cycles before promotion, 0 disables promotion
//   tokens_level                    current bucket level
//   grant_cnt                       per-source accepted grants, 32 bits each
//   token_stall_cycles              cycles with a valid DRAM source blocked only by tokens
//   contention_events               arbitration cycles with two or more eligible sources
module mem_req_arbiter_rr
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC  = 4,
   parameter int unsigned SIZE_W   = 16,
   parameter int unsigned TOK_W    = 16,
   parameter int unsigned WAIT_W   = 8,
   parameter int unsigned SRC_ID_W = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC-1:0]        src_is_dram,
   input  logic [NUM_SRC*SIZE_W-1:0] src_size,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      out_valid,
   output logic                      out_is_dram,
   output logic [SIZE_W-1:0]         out_size,
   output logic [SRC_ID_W-1:0]       out_src_id,
   input  logic                      out_ready,
   input  logic                      cfg_enable_tokens,
   input  logic [7:0]                cfg_tokens_per_cycle,
   input  logic [TOK_W-1:0]          cfg_token_capacity,
   input  logic [WAIT_W-1:0]         cfg_starve_limit,
   output logic [TOK_W-1:0]          tokens_level,
   output logic [NUM_SRC*CNT_W-1:0]  grant_cnt,
   output logic [CNT_W-1:0]          token_stall_cycles,
   output logic [CNT_W-1:0]          contention_events
);

   localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned NEL_W = $clog2(NUM_SRC_MAX + 1);

   // State
   logic                active_q;
   logic                out_valid_q, out_valid_d;
   logic                out_is_dram_q, out_is_dram_d;
   logic [SIZE_W-1:0]   out_size_q, out_size_d;
   logic [SRC_ID_W-1:0] out_src_id_q, out_src_id_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [TOK_W-1:0]    tokens_q, tokens_d;
   logic [WAIT_W-1:0]   wait_q [NUM_SRC];
   logic [WAIT_W-1:0]   wait_d [NUM_SRC];
   logic [CNT_W-1:0]    grant_cnt_q [NUM_SRC];
   logic [CNT_W-1:0]    grant_cnt_d [NUM_SRC];
   logic [CNT_W-1:0]    stall_q, stall_d;
   logic [CNT_W-1:0]    cont_q, cont_d;

   // Arbitration
   logic [31:0]         tok32, cap32, sub32;
   logic [31:0]         size32 [NUM_SRC];
   logic [NUM_SRC-1:0]  elig, tok_blocked, starve, rr_gnt, gnt;
   logic [PTR_W-1:0]    rr_idx, starve_idx, gnt_idx;
   logic [NEL_W-1:0]    n_elig;
   logic                rr_any, starve_any, can_load, arb_en, grant_any;

   always_comb begin
      tok32       = 32'(tokens_q);
      cap32       = 32'(cfg_token_capacity);
      elig        = '0;
      tok_blocked = '0;
      starve      = '0;
      n_elig      = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         size32[i] = 32'(src_size[i*SIZE_W +: SIZE_W]);
         // Oversize requests go through once the bucket is full, otherwise they never could.
         elig[i] = src_valid[i] & (~src_is_dram[i] | ~cfg_enable_tokens | (tok32 >= size32[i]) |
                                   ((size32[i] > cap32) & (tok32 == cap32)));
         tok_blocked[i] = src_valid[i] & src_is_dram[i] & cfg_enable_tokens & ~elig[i];
         starve[i] = elig[i] & (cfg_starve_limit != '0) & (wait_q[i] >= cfg_starve_limit);
         n_elig    = n_elig + NEL_W'(elig[i]);
      end
   end

   // Starvation path: lowest index wins.
   always_comb begin
      starve_idx = '0;
      starve_any = |starve;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (starve[i]) starve_idx = PTR_W'(i);
      end
   end

   rr_pick_onehot #(
      .N     (NUM_SRC),
      .IDX_W (PTR_W)
   ) u_rr_pick (
      .req_i (elig),
      .ptr_i (rr_ptr_q),
      .gnt_o (rr_gnt),
      .idx_o (rr_idx),
      .any_o (rr_any)
   );

   assign can_load  = ~out_valid_q | out_ready;
   // No grants until the bucket has been loaded on the first edge after reset.
   assign arb_en    = can_load & active_q;
   assign gnt_idx   = starve_any ? starve_idx : rr_idx;
   assign gnt       = starve_any ? (NUM_SRC'(1) << starve_idx) : rr_gnt;
   assign grant_any = arb_en & (starve_any | rr_any);
   assign src_ready = grant_any ? gnt : '0;

   always_comb begin
      out_valid_d   = out_valid_q;
      out_is_dram_d = out_is_dram_q;
      out_size_d    = out_size_q;
      out_src_id_d  = out_src_id_q;
      rr_ptr_d      = rr_ptr_q;
      sub32         = '0;
      tokens_d      = tokens_q;
      stall_d       = stall_q;
      cont_d        = cont_q;

      if (can_load) out_valid_d = grant_any;
      if (grant_any) begin
         out_is_dram_d = src_is_dram[gnt_idx];
         out_size_d    = src_size[32'(gnt_idx)*SIZE_W +: SIZE_W];
         out_src_id_d  = SRC_ID_W'(gnt_idx);
         rr_ptr_d      = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      end

      if (!active_q || !cfg_enable_tokens) begin
         tokens_d = cfg_token_capacity;
      end else begin
         // An oversize grant consumes whatever is in the bucket.
         if (grant_any && src_is_dram[gnt_idx]) begin
            sub32 = (size32[gnt_idx] > tok32) ? tok32 : size32[gnt_idx];
         end
         tokens_d = TOK_W'(sat_add_min(tok32, sub32, 32'(cfg_tokens_per_cycle), cap32));
      end

      if (active_q && (|tok_blocked)) stall_d = stall_q + 1'b1;
      if (arb_en && (n_elig >= NEL_W'(2))) cont_d = cont_q + 1'b1;

      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         grant_cnt_d[i] = grant_cnt_q[i] + CNT_W'(src_ready[i]);
         if (!src_valid[i] || src_ready[i]) begin
            wait_d[i] = '0;
         end else if (wait_q[i] != '1) begin
            wait_d[i] = wait_q[i] + 1'b1;
         end else begin
            wait_d[i] = wait_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q      <= 1'b0;
         out_valid_q   <= 1'b0;
         out_is_dram_q <= 1'b0;
         out_size_q    <= '0;
         out_src_id_q  <= '0;
         rr_ptr_q      <= '0;
         tokens_q      <= '0;
         stall_q       <= '0;
         cont_q        <= '0;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            wait_q[i]      <= '0;
            grant_cnt_q[i] <= '0;
         end
      end else begin
         active_q      <= 1'b1;
         out_valid_q   <= out_valid_d;
         out_is_dram_q <= out_is_dram_d;
         out_size_q    <= out_size_d;
         out_src_id_q  <= out_src_id_d;
         rr_ptr_q      <= rr_ptr_d;
         tokens_q      <= tokens_d;
         stall_q       <= stall_d;
         cont_q        <= cont_d;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            wait_q[i]      <= wait_d[i];
            grant_cnt_q[i] <= grant_cnt_d[i];
         end
      end
   end

   assign out_valid          = out_valid_q;
   assign out_is_dram        = out_is_dram_q;
   assign out_size           = out_size_q;
   assign out_src_id         = out_src_id_q;
   assign tokens_level       = tokens_q;
   assign token_stall_cycles = stall_q;
   assign contention_events  = cont_q;

   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         grant_cnt[i*CNT_W +: CNT_W] = grant_cnt_q[i];
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter_rr.sv
// Randomized bench for mem_req_arbiter_rr with a cycle-level reference model of the arbiter rules.
module tb_mem_req_arbiter_rr;

   localparam int NS = 4;
   localparam int SW = 16;
   localparam int TW = 16;
   localparam int WW = 8;
   localparam int IW = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NS-1:0]    src_valid, src_is_dram, src_ready;
   logic [NS*SW-1:0] src_size;
   logic             out_valid, out_is_dram, out_ready;
   logic [SW-1:0]    out_size;
   logic [IW-1:0]    out_src_id;
   logic             cfg_enable_tokens;
   logic [7:0]       cfg_tokens_per_cycle;
   logic [TW-1:0]    cfg_token_capacity;
   logic [WW-1:0]    cfg_starve_limit;
   logic [TW-1:0]    tokens_level;
   logic [NS*32-1:0] grant_cnt;
   logic [31:0]      token_stall_cycles, contention_events;

   always #5 clk = ~clk;

   mem_req_arbiter_rr #(
      .NUM_SRC  (NS),
      .SIZE_W   (SW),
      .TOK_W    (TW),
      .WAIT_W   (WW),
      .SRC_ID_W (IW)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .src_valid            (src_valid),
      .src_is_dram          (src_is_dram),
      .src_size             (src_size),
      .src_ready            (src_ready),
      .out_valid            (out_valid),
      .out_is_dram          (out_is_dram),
      .out_size             (out_size),
      .out_src_id           (out_src_id),
      .out_ready            (out_ready),
      .cfg_enable_tokens    (cfg_enable_tokens),
      .cfg_tokens_per_cycle (cfg_tokens_per_cycle),
      .cfg_token_capacity   (cfg_token_capacity),
      .cfg_starve_limit     (cfg_starve_limit),
      .tokens_level         (tokens_level),
      .grant_cnt            (grant_cnt),
      .token_stall_cycles   (token_stall_cycles),
      .contention_events    (contention_events)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int          m_tok, m_ptr, m_ov, m_osz, m_oid, m_od, m_active, m_last_pick;
   int          m_wait [NS];
   int unsigned m_gcnt [NS];
   int unsigned m_stall, m_cont;

   // Stimulus knobs (percentages)
   int p_valid, p_dram, p_ready, max_size;

   task automatic model_reset();
      m_tok = 0; m_ptr = 0; m_ov = 0; m_osz = 0; m_oid = 0; m_od = 0;
      m_active = 0; m_last_pick = -1; m_stall = 0; m_cont = 0;
      for (int i = 0; i < NS; i++) begin
         m_wait[i] = 0;
         m_gcnt[i] = 0;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_ready"}, 64'(src_ready), 64'd0);
      check_val({tag, "_ovalid"}, 64'(out_valid), 64'd0);
      check_val({tag, "_osize"}, 64'(out_size), 64'd0);
      check_val({tag, "_oid"}, 64'(out_src_id), 64'd0);
      check_val({tag, "_tokens"}, 64'(tokens_level), 64'd0);
      check_val({tag, "_gcnt"}, 64'(grant_cnt), 64'd0);
      check_val({tag, "_stall"}, 64'(token_stall_cycles), 64'd0);
      check_val({tag, "_cont"}, 64'(contention_events), 64'd0);
   endtask

   // Pending requests are held until accepted, occasionally withdrawn.
   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (!(src_valid[i] && m_last_pick != i && $urandom_range(99) >= 3)) begin
            src_valid[i]          = ($urandom_range(99) < p_valid);
            src_is_dram[i]        = ($urandom_range(99) < p_dram);
            src_size[i*SW +: SW]  = SW'($urandom_range(max_size - 1) + 1);
         end
      end
      out_ready = ($urandom_range(99) < p_ready);
   endtask

   // Compare at the falling edge, then advance the model across the rising edge.
   task automatic step();
      int            sz [NS];
      bit            el [NS];
      int            el_n, pick, cap, c, t, j;
      bit            can_load, any_blk;
      logic [NS-1:0] exp_rdy;
      @(negedge clk);
      cap      = int'(cfg_token_capacity);
      can_load = (m_ov == 0) || out_ready;
      el_n     = 0;
      any_blk  = 0;
      for (int i = 0; i < NS; i++) begin
         sz[i] = int'(src_size[i*SW +: SW]);
         el[i] = src_valid[i] && (!src_is_dram[i] || !cfg_enable_tokens || m_tok >= sz[i] ||
                                  (sz[i] > cap && m_tok == cap));
         if (el[i]) el_n++;
         if (src_valid[i] && src_is_dram[i] && cfg_enable_tokens && !el[i]) any_blk = 1;
      end
      pick = -1;
      if (m_active != 0 && can_load) begin
         if (cfg_starve_limit != 0) begin
            for (int i = 0; i < NS; i++)
               if (pick < 0 && el[i] && m_wait[i] >= int'(cfg_starve_limit)) pick = i;
         end
         for (int k = 0; k < NS; k++) begin
            j = (m_ptr + k) % NS;
            if (pick < 0 && el[j]) pick = j;
         end
      end
      exp_rdy = (pick >= 0) ? (NS'(1) << pick) : '0;

      check_val("src_ready", 64'(src_ready), 64'(exp_rdy));
      check_val("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov != 0) begin
         check_val("out_size", 64'(out_size), 64'(m_osz));
         check_val("out_src_id", 64'(out_src_id), 64'(m_oid));
         check_val("out_is_dram", 64'(out_is_dram), 64'(m_od));
      end
      check_val("tokens_level", 64'(tokens_level), 64'(m_tok));
      for (int i = 0; i < NS; i++) check_val($sformatf("grant_cnt%0d", i),
                                             64'(grant_cnt[i*32 +: 32]), 64'(m_gcnt[i]));
      check_val("token_stall", 64'(token_stall_cycles), 64'(m_stall));
      check_val("contention", 64'(contention_events), 64'(m_cont));

      if (m_active != 0 && any_blk) m_stall++;
      if (m_active != 0 && can_load && el_n >= 2) m_cont++;
      if (!m_active || !cfg_enable_tokens) begin
         m_tok = cap;
      end else begin
         c = 0;
         if (pick >= 0 && src_is_dram[pick]) c = (sz[pick] < m_tok) ? sz[pick] : m_tok;
         t     = m_tok - c + int'(cfg_tokens_per_cycle);
         m_tok = (t > cap) ? cap : t;
      end
      if (pick >= 0) begin
         m_ov = 1; m_osz = sz[pick]; m_oid = pick; m_od = int'(src_is_dram[pick]);
         m_gcnt[pick]++;
         m_ptr = (pick + 1) % NS;
      end else if (can_load) begin
         m_ov = 0;
      end
      for (int i = 0; i < NS; i++) begin
         if (!src_valid[i] || pick == i) m_wait[i] = 0;
         else if (m_wait[i] < 255) m_wait[i]++;
      end
      m_last_pick = pick;
      m_active    = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         drive();
         step();
      end
   endtask

   task automatic set_cfg(input int en, input int cap, input int tpc, input int lim);
      cfg_enable_tokens    = en[0];
      cfg_token_capacity   = TW'(cap);
      cfg_tokens_per_cycle = 8'(tpc);
      cfg_starve_limit     = WW'(lim);
   endtask

   task automatic mid_reset();
      int guard;
      guard = 0;
      p_valid = 100; p_ready = 30;
      while (m_ov == 0 && guard < 50) begin
         drive();
         step();
         guard++;
      end
      check_val("midrst_have_out", 64'(out_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1 check_reset_state("midrst");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      src_valid   = '1;
      src_is_dram = '0;
      src_size    = {NS{SW'(4)}};
      out_ready   = 1'b1;
      set_cfg(1, 64, 8, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_reset_state("reset");
      #2 reset_n = 1'b1;

      // Fairness: all SRAM, always valid, always ready
      p_valid = 100; p_dram = 0; p_ready = 100; max_size = 64;
      set_cfg(0, 1000, 8, 0);
      run(400);

      // Token gating, including oversize requests
      p_valid = 60; p_dram = 70; p_ready = 90; max_size = 128;
      set_cfg(1, 64, 8, 0);
      run(600);

      // Starvation promotion with a slow bucket
      p_valid = 90; p_dram = 40; p_ready = 95; max_size = 80;
      set_cfg(1, 64, 1, 10);
      run(600);

      // Heavy backpressure
      p_valid = 80; p_dram = 50; p_ready = 20; max_size = 150;
      set_cfg(1, 200, 16, 5);
      run(500);

      // Capacity lowered below the current level
      p_ready = 60;
      set_cfg(1, 30, 4, 3);
      run(300);

      // Mixed random configurations
      for (int ph = 0; ph < 6; ph++) begin
         p_valid = $urandom_range(100, 30); p_dram = $urandom_range(100);
         p_ready = $urandom_range(100, 10); max_size = $urandom_range(300, 2);
         set_cfg($urandom_range(1), $urandom_range(300, 8), $urandom_range(40),
                 $urandom_range(15));
         run(300);
      end

      // Asynchronous reset while a request is held at the output
      set_cfg(1, 100, 10, 4);
      p_dram = 30; max_size = 60;
      mid_reset();
      p_ready = 70;
      run(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
